// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: access size codes, FSM states and
// the alignment rule used at accept time.
package lsu_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic [1:0] {
    StIdle,
    StRd,
    StWr
  } lsu_state_e;

  // Reserved size 2'b11 is rejected the same way as a misaligned access.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic bad;
    case (size)
      SZ_B:    bad = 1'b0;
      SZ_H:    bad = addr_lo[0];
      SZ_W:    bad = (addr_lo != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: load extract/extend and sub-word store merge into an old word.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_addr_lo,
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_load_data,
  output logic [31:0] o_store_word
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_word[7:0];
    case (i_addr_lo)
      2'd0:    w_byte = i_word[7:0];
      2'd1:    w_byte = i_word[15:8];
      2'd2:    w_byte = i_word[23:16];
      default: w_byte = i_word[31:24];
    endcase
    w_half = i_addr_lo[1] ? i_word[31:16] : i_word[15:0];

    o_load_data = i_word;
    case (i_size)
      SZ_B:    o_load_data = {{24{~i_unsigned & w_byte[7]}}, w_byte};
      SZ_H:    o_load_data = {{16{~i_unsigned & w_half[15]}}, w_half};
      default: o_load_data = i_word;
    endcase
  end

  always_comb begin
    o_store_word = i_word;
    case (i_size)
      SZ_B: begin
        case (i_addr_lo)
          2'd0:    o_store_word[7:0]   = i_wdata[7:0];
          2'd1:    o_store_word[15:8]  = i_wdata[7:0];
          2'd2:    o_store_word[23:16] = i_wdata[7:0];
          default: o_store_word[31:24] = i_wdata[7:0];
        endcase
      end
      SZ_H: begin
        if (i_addr_lo[1]) o_store_word[31:16] = i_wdata[15:0];
        else              o_store_word[15:0]  = i_wdata[15:0];
      end
      default: o_store_word = i_wdata;
    endcase
  end

endmodule

// File: rtl/lsu_rmw.sv
// Load/store unit for a word-only memory; sub-word stores run as read-modify-write.
// Define LSU_RANGE_CHECK_EN to reject addresses beyond DMEM_WORDS*4 instead of aliasing.
module lsu_rmw
  import lsu_pkg::*;
#(
  parameter int unsigned DMEM_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  if (DMEM_WORDS == 0) begin : g_depth_check
    $error("DMEM_WORDS must be nonzero");
  end

  lsu_state_e  r_state;
  lsu_state_e  w_next_state;
  logic [31:0] r_addr;
  logic [1:0]  r_size;
  logic        r_we;
  logic        r_unsigned;
  logic [31:0] r_wdata;
  logic        r_rsp_valid;
  logic [31:0] r_rsp_rdata;
  logic        r_rsp_err;
  logic        w_bad;
  logic [31:0] w_load_data;
  logic [31:0] w_store_word;

`ifdef LSU_RANGE_CHECK_EN
  localparam logic [31:0] AddrLimit = 32'(DMEM_WORDS * 4);
  assign w_bad = is_misaligned(req_size, req_addr[1:0]) || (req_addr >= AddrLimit);
`else
  assign w_bad = is_misaligned(req_size, req_addr[1:0]);
`endif

  lsu_align u_align (
    .i_word      (mem_rdata),
    .i_addr_lo   (r_addr[1:0]),
    .i_size      (r_size),
    .i_unsigned  (r_unsigned),
    .i_wdata     (r_wdata),
    .o_load_data (w_load_data),
    .o_store_word(w_store_word)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= StIdle;
    else     r_state <= w_next_state;
  end

  // Memory strobes are gated with rst so a reset mid-sequence never lands a partial write.
  always_comb begin
    w_next_state = r_state;
    req_ready    = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    unique case (r_state)
      StIdle: begin
        req_ready = 1'b1;
        if (req_valid && !w_bad) begin
          w_next_state = (req_we && (req_size == SZ_W)) ? StWr : StRd;
        end
      end
      StRd: begin
        mem_read     = ~rst;
        w_next_state = r_we ? StWr : StIdle;
      end
      StWr: begin
        mem_write    = ~rst;
        w_next_state = StIdle;
      end
      default: w_next_state = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr      <= '0;
      r_size      <= '0;
      r_we        <= 1'b0;
      r_unsigned  <= 1'b0;
      r_wdata     <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        StIdle: begin
          if (req_valid) begin
            r_addr     <= req_addr;
            r_size     <= req_size;
            r_we       <= req_we;
            r_unsigned <= req_unsigned;
            r_wdata    <= req_wdata;
            if (w_bad) begin
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= 1'b1;
              r_rsp_rdata <= '0;
            end
          end
        end
        StRd: begin
          if (r_we) begin
            r_wdata <= w_store_word;
          end else begin
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= w_load_data;
          end
        end
        StWr: begin
          r_rsp_valid <= 1'b1;
          r_rsp_err   <= 1'b0;
          r_rsp_rdata <= '0;
        end
        default: ;
      endcase
    end
  end

  assign mem_addr  = {r_addr[31:2], 2'b00};
  assign mem_wdata = r_wdata;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_lsu_rmw.sv
// Bench for lsu_rmw: behavioural word memory, response scoreboard and per-scenario tasks.
module tb_lsu_rmw;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  always #5 clk = ~clk;

  lsu_rmw u_dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_we      (req_we),
    .req_size    (req_size),
    .req_unsigned(req_unsigned),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata)
  );

  logic [31:0] mem [0:255];
  logic        pl_en = 1'b0;
  logic [7:0]  pl_idx;
  logic [31:0] pl_data;

  assign mem_rdata = mem_read ? mem[mem_addr[9:2]] : 32'h0;

  always @(posedge clk) begin
    if (pl_en)          mem[pl_idx] <= pl_data;
    else if (mem_write) mem[mem_addr[9:2]] <= mem_wdata;
  end

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_errors = 0;

  always @(negedge clk) begin
    if (rsp_valid) begin
      n_checks++;
      if (sb_q.size() == 0) begin
        n_errors++;
        $display("FAIL rsp_unexpected got rdata=%h err=%b want no response", rsp_rdata, rsp_err);
      end else begin
        mon_e = sb_q.pop_front();
        if (rsp_rdata !== mon_e.rdata || rsp_err !== mon_e.err) begin
          n_errors++;
          $display("FAIL rsp_data got rdata=%h err=%b want rdata=%h err=%b",
                   rsp_rdata, rsp_err, mon_e.rdata, mon_e.err);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  int          lat;
  logic [7:0]  rd_m;
  logic [7:0]  wr_m;
  logic [7:0]  rdy_m;
  logic [31:0] wd;

  task automatic preload(input logic [7:0] idx, input logic [31:0] data);
    @(posedge clk); #1;
    pl_en = 1'b1; pl_idx = idx; pl_data = data;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  // One request; bit i of each mask is the signal seen in cycle N+i.
  task automatic access(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input logic exp_err);
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    sb_q.push_back({exp_rdata, exp_err});
    @(negedge clk);
    rd_m = '0; wr_m = '0; rdy_m = '0; wd = '0; lat = 0;
    rdy_m[0] = req_ready; rd_m[0] = mem_read; wr_m[0] = mem_write;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int i = 1; i < 8; i++) begin
      @(negedge clk);
      rd_m[i] = mem_read; wr_m[i] = mem_write; rdy_m[i] = req_ready;
      if (mem_write) wd = mem_wdata;
      if (rsp_valid) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (mem_write !== 1'b0 || mem_read !== 1'b0) begin
        n_errors++;
        $display("FAIL reset_mem_strobe got rd=%b wr=%b want 0 0", mem_read, mem_write);
      end
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 1'b1) begin
      n_errors++; $display("FAIL reset_ready got %b want 1", req_ready);
    end
    n_checks++;
    if (rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0) begin
      n_errors++;
      $display("FAIL reset_rsp got v=%b e=%b d=%h want 0 0 0", rsp_valid, rsp_err, rsp_rdata);
    end
  endtask

  typedef struct packed {
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] exp;
  } ld_t;

  task automatic test_loads();
    ld_t lds[8];
    lds[0] = {SZ_B, 1'b0, 32'h12, 32'hFFFF_FF99};
    lds[1] = {SZ_B, 1'b1, 32'h12, 32'h0000_0099};
    lds[2] = {SZ_H, 1'b0, 32'h12, 32'hFFFF_8899};
    lds[3] = {SZ_H, 1'b1, 32'h12, 32'h0000_8899};
    lds[4] = {SZ_B, 1'b0, 32'h10, 32'hFFFF_FFBB};
    lds[5] = {SZ_B, 1'b1, 32'h13, 32'h0000_0088};
    lds[6] = {SZ_H, 1'b0, 32'h10, 32'hFFFF_AABB};
    lds[7] = {SZ_W, 1'b0, 32'h10, 32'h8899_AABB};
    preload(8'h04, 32'h8899_AABB);
    for (int i = 0; i < 8; i++) begin
      access(1'b0, lds[i].size, lds[i].uns, lds[i].addr, 32'h0, lds[i].exp, 1'b0);
      n_checks++;
      if (lat != 2) begin
        n_errors++; $display("FAIL load_latency[%0d] got %0d want 2", i, lat);
      end
      n_checks++;
      if (rd_m !== 8'b0000_0010 || wr_m !== 8'b0) begin
        n_errors++; $display("FAIL load_strobes[%0d] got rd=%b wr=%b want 00000010 0", i, rd_m, wr_m);
      end
      n_checks++;
      if (rdy_m !== 8'b0000_0101) begin
        n_errors++; $display("FAIL load_ready[%0d] got %b want 00000101", i, rdy_m);
      end
    end
    repeat (2) @(negedge clk);
    n_checks++;
    if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h8899_AABB) begin
      n_errors++;
      $display("FAIL rsp_hold got v=%b d=%h want 0 8899aabb", rsp_valid, rsp_rdata);
    end
  endtask

  task automatic test_store_sub();
    access(1'b1, SZ_B, 1'b0, 32'h11, 32'h0000_005A, 32'h0, 1'b0);
    n_checks++;
    if (lat != 3) begin n_errors++; $display("FAIL sb_latency got %0d want 3", lat); end
    n_checks++;
    if (rd_m !== 8'b0000_0010 || wr_m !== 8'b0000_0100) begin
      n_errors++; $display("FAIL sb_strobes got rd=%b wr=%b want 00000010 00000100", rd_m, wr_m);
    end
    n_checks++;
    if (wd !== 32'h8899_5ABB) begin n_errors++; $display("FAIL sb_wdata got %h want 88995abb", wd); end
    n_checks++;
    if (rdy_m !== 8'b0000_1001) begin n_errors++; $display("FAIL sb_ready got %b want 00001001", rdy_m); end
    access(1'b1, SZ_H, 1'b0, 32'h12, 32'hFFFF_BEEF, 32'h0, 1'b0);
    n_checks++;
    if (wd !== 32'hBEEF_5ABB || lat != 3) begin
      n_errors++; $display("FAIL sh_wdata got %h lat %0d want beef5abb lat 3", wd, lat);
    end
    access(1'b0, SZ_W, 1'b0, 32'h10, 32'h0, 32'hBEEF_5ABB, 1'b0);
  endtask

  task automatic test_back_to_back();
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b1; req_size = SZ_W; req_unsigned = 1'b0;
    req_addr = 32'h20; req_wdata = 32'h1234_5678;
    sb_q.push_back({32'h0, 1'b0});
    sb_q.push_back({32'h1234_5678, 1'b0});
    @(posedge clk); #1;
    req_we = 1'b0; req_wdata = 32'h0;
    @(negedge clk);
    n_checks++;
    if (mem_write !== 1'b1 || mem_wdata !== 32'h1234_5678 || mem_addr !== 32'h20 || req_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL b2b_sw_write got wr=%b d=%h a=%h rdy=%b want 1 12345678 20 0",
               mem_write, mem_wdata, mem_addr, req_ready);
    end
    @(negedge clk);
    n_checks++;
    if (rsp_valid !== 1'b1 || req_ready !== 1'b1) begin
      n_errors++; $display("FAIL b2b_rsp_ready got v=%b rdy=%b want 1 1", rsp_valid, req_ready);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (mem_read !== 1'b1 || mem_addr !== 32'h20) begin
      n_errors++; $display("FAIL b2b_lw_read got rd=%b a=%h want 1 20", mem_read, mem_addr);
    end
    @(negedge clk);
    n_checks++;
    if (rsp_valid !== 1'b1) begin n_errors++; $display("FAIL b2b_lw_rsp got %b want 1", rsp_valid); end
  endtask

  task automatic test_misaligned();
    logic [1:0]  sz [5];
    logic [31:0] ad [5];
    logic        we [5];
    sz[0] = SZ_W;  ad[0] = 32'h22; we[0] = 1'b0;
    sz[1] = SZ_H;  ad[1] = 32'h21; we[1] = 1'b1;
    sz[2] = 2'b11; ad[2] = 32'h20; we[2] = 1'b0;
    sz[3] = SZ_W;  ad[3] = 32'h23; we[3] = 1'b1;
    sz[4] = SZ_H;  ad[4] = 32'h13; we[4] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      access(we[i], sz[i], 1'b0, ad[i], 32'hDEAD_BEEF, 32'h0, 1'b1);
      n_checks++;
      if (lat != 1 || rd_m !== 8'b0 || wr_m !== 8'b0) begin
        n_errors++;
        $display("FAIL misalign[%0d] got lat=%0d rd=%b wr=%b want 1 0 0", i, lat, rd_m, wr_m);
      end
    end
    n_checks++;
    if (mem[8] !== 32'h1234_5678) begin
      n_errors++; $display("FAIL misalign_mem got %h want 12345678", mem[8]);
    end
`ifdef LSU_RANGE_CHECK_EN
    access(1'b0, SZ_W, 1'b0, 32'h400, 32'h0, 32'h0, 1'b1);
    n_checks++;
    if (lat != 1 || rd_m !== 8'b0) begin
      n_errors++; $display("FAIL range_err got lat=%0d rd=%b want 1 0", lat, rd_m);
    end
`else
    access(1'b0, SZ_W, 1'b0, 32'h410, 32'h0, 32'hBEEF_5ABB, 1'b0);
    n_checks++;
    if (lat != 2) begin n_errors++; $display("FAIL alias_latency got %0d want 2", lat); end
`endif
  endtask

  task automatic test_reset_mid();
    int wr_seen;
    preload(8'h10, 32'h1122_3344);
    access(1'b0, SZ_W, 1'b0, 32'h40, 32'h0, 32'h1122_3344, 1'b0);
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b1; req_size = SZ_B; req_unsigned = 1'b0;
    req_addr = 32'h41; req_wdata = 32'h77;
    @(posedge clk); #1;
    req_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (mem_read !== 1'b0 || mem_write !== 1'b0) begin
      n_errors++; $display("FAIL rstmid_gate got rd=%b wr=%b want 0 0", mem_read, mem_write);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
      n_errors++;
      $display("FAIL rstmid_outputs got rdy=%b v=%b d=%h e=%b want 1 0 0 0",
               req_ready, rsp_valid, rsp_rdata, rsp_err);
    end
    wr_seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (mem_write) wr_seen++;
    end
    n_checks++;
    if (wr_seen != 0 || mem[16] !== 32'h1122_3344) begin
      n_errors++; $display("FAIL rstmid_nowrite got writes=%0d mem=%h want 0 11223344", wr_seen, mem[16]);
    end
    access(1'b0, SZ_B, 1'b1, 32'h41, 32'h0, 32'h0000_0033, 1'b0);
    n_checks++;
    if (lat != 2) begin n_errors++; $display("FAIL rstmid_next_lat got %0d want 2", lat); end
    access(1'b1, SZ_B, 1'b0, 32'h41, 32'h77, 32'h0, 1'b0);
    access(1'b0, SZ_W, 1'b0, 32'h40, 32'h0, 32'h1122_7744, 1'b0);
  endtask

  initial begin
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = '0;
    test_reset();
    test_loads();
    test_store_sub();
    test_back_to_back();
    test_misaligned();
    test_reset_mid();
    repeat (3) @(negedge clk);
    n_checks++;
    if (sb_q.size() != 0) begin
      n_errors++; $display("FAIL sb_drain got %0d pending want 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
